// File: rtl/cpu_bus_responder.sv
// CPU bus target: decodes RAM ($0000-$1FFF), PPU regs ($2000-$3FFF), ROM ($8000-$FFFF), OAM DMA on $4014 writes.
// Latency: cpu_rdata registered one cycle after the address; PPU writes issue the cycle after acceptance.
// Backpressure: cpu_halt freezes the CPU for the 513 DMA cycles; OPEN_BUS_EN makes unmapped reads return the last bus value.
module cpu_bus_responder #(
    parameter int         RAM_AW      = 11,
    parameter int         PRG_AW      = 15,
    parameter logic [2:0] OAM_REG_IDX = 3'd4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    input  logic              cpu_we,
    input  logic              cpu_re,
    output logic              cpu_halt,
    output logic [PRG_AW-1:0] prg_addr,
    input  logic [7:0]        prg_rdata,
    output logic [2:0]        ppu_reg_addr,
    output logic [7:0]        ppu_reg_wdata,
    input  logic [7:0]        ppu_reg_rdata,
    output logic              ppu_reg_we,
    output logic              ppu_reg_re
);

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_RD, S_WR, S_TAIL} state_t;

    state_t      state;
    logic [7:0]  dma_page;
    logic [7:0]  dma_cnt;
    logic [15:0] dma_addr;
    logic [2:0]  ppu_addr_q;
    logic [7:0]  ram [2**RAM_AW];

    logic        idle;
    logic        cpu_is_ram, cpu_is_ppu, cpu_is_rom, cpu_is_dma;
    logic        dma_is_ram, dma_is_ppu, dma_is_rom;
    logic        ppu_rd_now;
    logic        cpu_rd_upd;
    logic [7:0]  cpu_rd_val;
    logic [7:0]  dma_byte;
    logic [7:0]  cpu_unmapped;
    logic [7:0]  dma_unmapped;

    assign idle       = (state == S_IDLE);
    assign dma_addr   = {dma_page, dma_cnt};

    assign cpu_is_ram = (cpu_addr[15:13] == 3'b000);
    assign cpu_is_ppu = (cpu_addr[15:13] == 3'b001);
    assign cpu_is_rom = cpu_addr[15];
    assign cpu_is_dma = (cpu_addr == 16'h4014);

    assign dma_is_ram = (dma_addr[15:13] == 3'b000);
    assign dma_is_ppu = (dma_addr[15:13] == 3'b001);
    assign dma_is_rom = dma_addr[15];

    // ROM port is shared: the DMA engine borrows it while the CPU is frozen.
    assign prg_addr = (state == S_RD) ? dma_addr[PRG_AW-1:0] : cpu_addr[PRG_AW-1:0];

    // PPU reads are side-effecting, so the strobe only fires on an explicit read with no write.
    assign ppu_rd_now   = rst && idle && cpu_is_ppu && cpu_re && !cpu_we;
    assign ppu_reg_re   = ppu_rd_now;
    assign ppu_reg_addr = ppu_rd_now ? cpu_addr[2:0] : ppu_addr_q;

`ifdef OPEN_BUS_EN
    logic [7:0] dma_last;
    assign cpu_unmapped = cpu_rdata;
    assign dma_unmapped = dma_last;
`else
    assign cpu_unmapped = 8'h00;
    assign dma_unmapped = 8'h00;
`endif

    always_comb begin
        cpu_rd_upd = 1'b0;
        cpu_rd_val = 8'h00;
        if (idle && !cpu_we) begin
            if (cpu_is_ram) begin
                cpu_rd_upd = 1'b1;
                cpu_rd_val = ram[cpu_addr[RAM_AW-1:0]];
            end else if (cpu_is_ppu) begin
                cpu_rd_upd = cpu_re;
                cpu_rd_val = ppu_reg_rdata;
            end else if (cpu_is_rom) begin
                cpu_rd_upd = 1'b1;
                cpu_rd_val = prg_rdata;
            end else begin
                cpu_rd_upd = 1'b1;
                cpu_rd_val = cpu_unmapped;
            end
        end
    end

    always_comb begin
        dma_byte = dma_unmapped;
        if (dma_is_ram)
            dma_byte = ram[dma_addr[RAM_AW-1:0]];
        else if (dma_is_ppu)
            dma_byte = 8'h00;
        else if (dma_is_rom)
            dma_byte = prg_rdata;
    end

    always_ff @(posedge clk) begin
        if (idle && cpu_we && cpu_is_ram)
            ram[cpu_addr[RAM_AW-1:0]] <= cpu_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            dma_page      <= 8'h00;
            dma_cnt       <= 8'h00;
            cpu_halt      <= 1'b0;
            cpu_rdata     <= 8'h00;
            ppu_reg_we    <= 1'b0;
            ppu_addr_q    <= 3'd0;
            ppu_reg_wdata <= 8'h00;
`ifdef OPEN_BUS_EN
            dma_last      <= 8'h00;
`endif
        end else begin
            ppu_reg_we <= 1'b0;
            if (cpu_rd_upd)
                cpu_rdata <= cpu_rd_val;
            case (state)
                S_IDLE: begin
                    if (cpu_we && cpu_is_ppu) begin
                        ppu_reg_we    <= 1'b1;
                        ppu_addr_q    <= cpu_addr[2:0];
                        ppu_reg_wdata <= cpu_wdata;
                    end else if (cpu_we && cpu_is_dma) begin
                        state    <= S_ALIGN;
                        dma_page <= cpu_wdata;
                        dma_cnt  <= 8'h00;
                        cpu_halt <= 1'b1;
                    end
                end
                S_ALIGN: state <= S_RD;
                S_RD: begin
                    state         <= S_WR;
                    ppu_reg_we    <= 1'b1;
                    ppu_addr_q    <= OAM_REG_IDX;
                    ppu_reg_wdata <= dma_byte;
`ifdef OPEN_BUS_EN
                    dma_last      <= dma_byte;
`endif
                end
                S_WR: begin
                    dma_cnt <= dma_cnt + 8'd1;
                    if (dma_cnt == 8'hFF) begin
                        state    <= S_TAIL;
                        cpu_halt <= 1'b0;
                    end else begin
                        state <= S_RD;
                    end
                end
                // CPU comes out of halt with its write strobe still asserted; swallow it.
                S_TAIL:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
